// File: rtl/tx_unit.sv
// Order-driven RAM-to-stream transmitter: queues up to MAX_ORDERS requests and
// streams ORDER_IMGS samples per order from a wrapping RAM read pointer.
module tx_unit #(
  parameter int FIFO_DATA  = 25,
  parameter int ORDER_IMGS = 50,
  parameter int MAX_ORDERS = 5,
  parameter int RAM_DEPTH  = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_en,
  input  logic                 on,
  input  logic                 off,
  input  logic                 order_req,
  input  logic [FIFO_DATA-1:0] ram_data,
  input  logic                 ready,
  output logic                 ram_rd,
  output logic [6:0]           ramadd,
  output logic [FIFO_DATA-1:0] data_out,
  output logic                 valid,
  output logic                 order_done,
  output logic                 order_full,
  output logic                 no_order,
  output logic                 sending
);

  localparam int CNT_W = $clog2(ORDER_IMGS + 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, DONE} state_e;

  state_e               state_q, state_d;
  logic [2:0]           order_count_q, order_count_d;
  logic [CNT_W-1:0]     sent_cnt_q, sent_cnt_d;
  logic [6:0]           rd_ptr_q, rd_ptr_d;
  logic [FIFO_DATA-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 go;
  logic                 req_ok;

  assign go = tx_en && on && !off;

  // A request at a full queue is still taken when a slot frees on the same edge.
  assign req_ok = order_req && ((order_count_q < 3'(MAX_ORDERS)) || order_done);

  always_comb begin
    order_count_d = order_count_q;
    case ({req_ok, order_done})
      2'b10:   order_count_d = order_count_q + 3'd1;
      2'b01:   order_count_d = order_count_q - 3'd1;
      default: order_count_d = order_count_q;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d    = state_q;
    sent_cnt_d = sent_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ram_rd     = 1'b0;
    case (state_q)
      IDLE: begin
        if ((order_count_q != 3'd0) && go) state_d = FETCH;
      end
      FETCH: begin
        if (go) begin
          ram_rd  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        data_d   = ram_data;
        valid_d  = 1'b1;
        rd_ptr_d = (rd_ptr_q == 7'(RAM_DEPTH - 1)) ? 7'd0 : rd_ptr_q + 7'd1;
        state_d  = SEND;
      end
      SEND: begin
        if (ready) begin
          valid_d    = 1'b0;
          sent_cnt_d = sent_cnt_q + 1'b1;
          state_d    = (sent_cnt_q == CNT_W'(ORDER_IMGS - 1)) ? DONE : FETCH;
        end
      end
      DONE: begin
        sent_cnt_d = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      order_count_q <= '0;
      sent_cnt_q    <= '0;
      rd_ptr_q      <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      order_count_q <= order_count_d;
      sent_cnt_q    <= sent_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
    end
  end

  assign ramadd     = rd_ptr_q;
  assign data_out   = data_q;
  assign valid      = valid_q;
  assign order_done = (state_q == DONE);
  assign order_full = (order_count_q == 3'(MAX_ORDERS));
  assign no_order   = (order_count_q == 3'd0);
  assign sending    = (state_q != IDLE);

endmodule

// File: tb/tb_tx_unit.sv
// Directed bench for tx_unit: reset, single order, back-to-back with wrap,
// backpressure/off hold, order queue limits and reset mid-order.
module tb_tx_unit;

  localparam int W    = 25;
  localparam int IMGS = 50;
  localparam int DEP  = 100;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         tx_en = 1'b0;
  logic         on = 1'b0;
  logic         off = 1'b0;
  logic         order_req = 1'b0;
  logic [W-1:0] ram_data = '0;
  logic         ready = 1'b0;
  logic         ram_rd;
  logic [6:0]   ramadd;
  logic [W-1:0] data_out;
  logic         valid;
  logic         order_done;
  logic         order_full;
  logic         no_order;
  logic         sending;

  logic [W-1:0] mem [0:127];
  int pass_cnt = 0;
  int total_cnt = 0;

  tx_unit #(.FIFO_DATA(W), .ORDER_IMGS(IMGS), .MAX_ORDERS(5), .RAM_DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .on(on), .off(off), .order_req(order_req),
    .ram_data(ram_data), .ready(ready), .ram_rd(ram_rd), .ramadd(ramadd),
    .data_out(data_out), .valid(valid), .order_done(order_done),
    .order_full(order_full), .no_order(no_order), .sending(sending)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data appears the cycle after the strobe.
  always @(posedge clk) if (ram_rd) ram_data <= mem[ramadd];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    order_req = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Runs until n_done order_done pulses are seen, checking every accepted sample.
  task automatic run_orders(input int start_idx, input int n_done, input bit inject,
                            input int max_cycles, output int next_idx,
                            output int first_valid_c, output int done_c);
    int idx, dones, samples;
    idx = start_idx; dones = 0; samples = 0;
    first_valid_c = -1; done_c = -1;
    for (int c = 0; c < max_cycles && dones < n_done; c++) begin
      @(posedge clk); #1;
      order_req = 1'b0;
      if (valid && ready) begin
        if (first_valid_c < 0) first_valid_c = c;
        total_cnt++;
        if (data_out !== mem[idx % DEP])
          $display("FAIL sample[%0d]: data_out=%0h expected %0h", idx % DEP, data_out, mem[idx % DEP]);
        else pass_cnt++;
        idx++; samples++;
      end
      if (order_done) begin
        dones++; done_c = c;
        if (dones == n_done && inject) order_req = 1'b1;
      end
    end
    total_cnt++;
    if (dones !== n_done) $display("FAIL order_done_count: got %0d expected %0d", dones, n_done);
    else pass_cnt++;
    total_cnt++;
    if (samples !== n_done * IMGS) $display("FAIL sample_count: got %0d expected %0d", samples, n_done * IMGS);
    else pass_cnt++;
    next_idx = idx % DEP;
  endtask

  task automatic test_reset();
    tx_en = 1'b1; on = 1'b1; off = 1'b0; ready = 1'b1;
    do_reset();
    total_cnt++; if (ram_rd !== 1'b0) $display("FAIL reset_ram_rd: got %b expected 0", ram_rd); else pass_cnt++;
    total_cnt++; if (order_full !== 1'b0) $display("FAIL reset_order_full: got %b expected 0", order_full); else pass_cnt++;
    total_cnt++; if (no_order !== 1'b1) $display("FAIL reset_no_order: got %b expected 1", no_order); else pass_cnt++;
    total_cnt++; if (sending !== 1'b0) $display("FAIL reset_sending: got %b expected 0", sending); else pass_cnt++;
    total_cnt++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid); else pass_cnt++;
    total_cnt++; if (order_done !== 1'b0) $display("FAIL reset_order_done: got %b expected 0", order_done); else pass_cnt++;
    total_cnt++; if (ramadd !== 7'd0) $display("FAIL reset_ramadd: got %0d expected 0", ramadd); else pass_cnt++;
    total_cnt++; if (data_out !== '0) $display("FAIL reset_data_out: got %0h expected 0", data_out); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (sending !== 1'b0) $display("FAIL idle_without_order: sending=%b expected 0", sending); else pass_cnt++;
  endtask

  task automatic test_single_order();
    int nidx, fv, dc;
    do_reset();
    tx_en = 1'b1; on = 1'b1; off = 1'b0; ready = 1'b1;
    order_req = 1'b1;
    run_orders(0, 1, 1'b0, 400, nidx, fv, dc);
    total_cnt++; if (fv !== 3) $display("FAIL first_valid_latency: got %0d expected 3", fv); else pass_cnt++;
    total_cnt++; if (dc !== 151) $display("FAIL order_done_cycle: got %0d expected 151", dc); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (order_done !== 1'b0) $display("FAIL done_one_cycle: order_done=%b expected 0", order_done); else pass_cnt++;
    total_cnt++; if (no_order !== 1'b1) $display("FAIL single_no_order: got %b expected 1", no_order); else pass_cnt++;
    total_cnt++; if (ramadd !== 7'd50) $display("FAIL single_ramadd: got %0d expected 50", ramadd); else pass_cnt++;
    total_cnt++; if (sending !== 1'b0) $display("FAIL single_idle: sending=%b expected 0", sending); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int nidx, fv, dc;
    do_reset();
    tx_en = 1'b1; on = 1'b1; off = 1'b0; ready = 1'b1;
    order_req = 1'b1;
    @(posedge clk); #1;
    order_req = 1'b1;
    run_orders(0, 2, 1'b0, 800, nidx, fv, dc);
    @(posedge clk); #1;
    total_cnt++; if (ramadd !== 7'd0) $display("FAIL wrap_ramadd: got %0d expected 0", ramadd); else pass_cnt++;
    total_cnt++; if (no_order !== 1'b1) $display("FAIL wrap_no_order: got %b expected 1", no_order); else pass_cnt++;
    order_req = 1'b1;
    run_orders(0, 1, 1'b0, 400, nidx, fv, dc);
    @(posedge clk); #1;
    total_cnt++; if (ramadd !== 7'd50) $display("FAIL third_ramadd: got %0d expected 50", ramadd); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int n;
    bit held;
    do_reset();
    tx_en = 1'b1; on = 1'b1; off = 1'b0; ready = 1'b0;
    order_req = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      order_req = 1'b0;
      n++;
    end while (!valid && n < 10);
    total_cnt++; if (valid !== 1'b1) $display("FAIL bp_first_valid: valid=%b after %0d cycles", valid, n); else pass_cnt++;
    total_cnt++; if (data_out !== mem[0]) $display("FAIL bp_first_data: got %0h expected %0h", data_out, mem[0]); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      tx_en = i[0];
      @(posedge clk); #1;
      total_cnt++;
      if (valid !== 1'b1 || data_out !== mem[0])
        $display("FAIL bp_hold[%0d]: valid=%b data=%0h expected 1/%0h", i, valid, data_out, mem[0]);
      else pass_cnt++;
    end
    tx_en = 1'b1; off = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (valid !== 1'b1 || data_out !== mem[0] || ram_rd !== 1'b0)
        $display("FAIL off_hold[%0d]: valid=%b data=%0h ram_rd=%b expected 1/%0h/0", i, valid, data_out, ram_rd, mem[0]);
      else pass_cnt++;
    end
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    total_cnt++; if (valid !== 1'b0) $display("FAIL off_accept: valid=%b expected 0", valid); else pass_cnt++;
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (ram_rd !== 1'b0 || sending !== 1'b1) held = 1'b0;
      @(posedge clk); #1;
    end
    total_cnt++; if (held !== 1'b1) $display("FAIL off_no_fetch: ram_rd asserted or left FETCH while off=1"); else pass_cnt++;
    off = 1'b0;
    #1;
    total_cnt++;
    if (ram_rd !== 1'b1 || ramadd !== 7'd1)
      $display("FAIL off_release_fetch: ram_rd=%b ramadd=%0d expected 1/1", ram_rd, ramadd);
    else pass_cnt++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total_cnt++;
    if (valid !== 1'b1 || data_out !== mem[1])
      $display("FAIL bp_second_sample: valid=%b data=%0h expected 1/%0h", valid, data_out, mem[1]);
    else pass_cnt++;
  endtask

  task automatic test_queue();
    int nidx, fv, dc;
    bit idle_ok;
    do_reset();
    tx_en = 1'b0; on = 1'b1; off = 1'b0; ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      order_req = 1'b1;
      @(posedge clk); #1;
      order_req = 1'b0;
      total_cnt++;
      if (order_full !== (i >= 4))
        $display("FAIL queue_full[%0d]: order_full=%b expected %b", i, order_full, (i >= 4));
      else pass_cnt++;
      @(posedge clk); #1;
    end
    total_cnt++; if (no_order !== 1'b0) $display("FAIL queue_no_order: got %b expected 0", no_order); else pass_cnt++;
    total_cnt++; if (sending !== 1'b0) $display("FAIL queue_go_low_idle: sending=%b expected 0", sending); else pass_cnt++;
    tx_en = 1'b1;
    run_orders(0, 1, 1'b1, 400, nidx, fv, dc);
    @(posedge clk); #1;
    order_req = 1'b0;
    total_cnt++; if (order_full !== 1'b1) $display("FAIL req_with_done_at_full: order_full=%b expected 1", order_full); else pass_cnt++;
    run_orders(nidx, 5, 1'b0, 5 * 400, nidx, fv, dc);
    @(posedge clk); #1;
    total_cnt++; if (no_order !== 1'b1) $display("FAIL queue_drained: no_order=%b expected 1", no_order); else pass_cnt++;
    idle_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (sending !== 1'b0) idle_ok = 1'b0;
      @(posedge clk); #1;
    end
    total_cnt++; if (idle_ok !== 1'b1) $display("FAIL queue_extra_order: sending seen after drain"); else pass_cnt++;
  endtask

  task automatic test_reset_mid_order();
    int n, nidx, fv, dc;
    do_reset();
    tx_en = 1'b1; on = 1'b1; off = 1'b0; ready = 1'b1;
    order_req = 1'b1;
    @(posedge clk); #1;
    order_req = 1'b1;
    n = 0;
    for (int c = 0; c < 200 && n < 20; c++) begin
      @(posedge clk); #1;
      order_req = 1'b0;
      if (valid) n++;
    end
    total_cnt++;
    if (n !== 20 || data_out !== mem[19])
      $display("FAIL mid_20th_sample: count=%0d data=%0h expected 20/%0h", n, data_out, mem[19]);
    else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total_cnt++; if (valid !== 1'b0) $display("FAIL mid_reset_valid: got %b expected 0", valid); else pass_cnt++;
    total_cnt++; if (sending !== 1'b0) $display("FAIL mid_reset_idle: sending=%b expected 0", sending); else pass_cnt++;
    total_cnt++; if (no_order !== 1'b1) $display("FAIL mid_reset_no_order: got %b expected 1", no_order); else pass_cnt++;
    total_cnt++; if (ramadd !== 7'd0) $display("FAIL mid_reset_ramadd: got %0d expected 0", ramadd); else pass_cnt++;
    order_req = 1'b1;
    run_orders(0, 1, 1'b0, 400, nidx, fv, dc);
    total_cnt++; if (fv !== 3) $display("FAIL restart_latency: got %0d expected 3", fv); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 128; i++)
      mem[i] = (i < DEP) ? W'((i * 32'h0001_0203) ^ 32'h0155_AA55) : '0;
    test_reset();
    test_single_order();
    test_back_to_back();
    test_backpressure();
    test_queue();
    test_reset_mid_order();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
